// File: rtl/fb_scanout_reader.sv
// Frame scanout reader: credit-limited Avalon-MM burst reads into a first-word-fall-through FIFO.
// Defining FB_SCANOUT_UNDERFLOW_CNT_EN adds a saturating underflow_count output.
module fb_scanout_reader #(
    parameter int FRAME_WORDS = 153600,
    parameter int BURST_LEN   = 8,
    parameter int FIFO_DEPTH  = 64
) (
    input  logic        systemClock,
    input  logic        reset_n,
    input  logic [28:0] fb_base,
    input  logic        frame_start,
    output logic [28:0] address,
    output logic [7:0]  burstcount,
    output logic        read,
    input  logic        waitrequest,
    input  logic [63:0] readdata,
    input  logic        readdatavalid,
    output logic [7:0]  byteenable,
    output logic [63:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        busy,
    output logic        underflow
`ifdef FB_SCANOUT_UNDERFLOW_CNT_EN
    ,
    output logic [15:0] underflow_count
`endif
);

    // state   | meaning
    // S_IDLE  | no frame in flight; late beats of a finished frame still enter the FIFO
    // S_REQ   | issuing credit-limited read bursts
    // S_ABORT | restart seen while a command was stalled; waiting for it to be accepted
    // S_DRAIN | discarding beats of the aborted frame until nothing is pending
    // S_FLUSH | empty the FIFO, then fetch from the newly latched base
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_ABORT = 3'd2,
        S_DRAIN = 3'd3,
        S_FLUSH = 3'd4
    } state_t;

    localparam int          AW    = $clog2(FIFO_DEPTH);
    localparam int          FW    = AW + 1;
    localparam logic [7:0]  BL    = 8'(BURST_LEN);
    localparam logic [17:0] FRAME = 18'(FRAME_WORDS);
    localparam logic [15:0] DEPTH = 16'(FIFO_DEPTH);

    state_t        state_q, state_d;
    logic [28:0]   next_addr_q, next_addr_d;
    logic [17:0]   words_left_q, words_left_d;
    logic [7:0]    pending_q, pending_d;
    logic          read_q, read_d;
    logic [28:0]   addr_q, addr_d;
    logic [7:0]    bc_q, bc_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] rd_next;
    logic [63:0]   head_q, head_d;
    logic          underflow_q, underflow_d;
    logic [63:0]   mem_q [FIFO_DEPTH];

    logic          issue_ok, discard, flush;
    logic          accept, beat, push, pop, uf_cond;
    logic [7:0]    acc_bc, burst_after;
    logic [17:0]   wl_after;
    logic [28:0]   addr_after;
    logic [15:0]   credit_after;

    always_ff @(posedge systemClock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d = (pending_q != 8'd0) ? S_DRAIN : S_REQ;
                end
            end
            S_REQ: begin
                if (frame_start) begin
                    state_d = (read_q && waitrequest) ? S_ABORT : S_DRAIN;
                end else if (words_left_q == 18'd0 && !read_q) begin
                    state_d = S_IDLE;
                end
            end
            S_ABORT: begin
                if (accept) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!frame_start && pending_q == 8'd0) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                state_d = frame_start ? S_DRAIN : S_REQ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != S_IDLE);
        issue_ok = (state_q == S_REQ) && !frame_start;
        discard  = frame_start || !((state_q == S_IDLE) || (state_q == S_REQ));
        flush    = frame_start || (state_q == S_FLUSH);
    end

    always_comb begin
        accept       = read_q && !waitrequest;
        acc_bc       = accept ? bc_q : 8'd0;
        beat         = readdatavalid && (pending_q != 8'd0);
        push         = beat && !discard;
        pop          = pix_valid && pix_ready && !flush;
        wl_after     = words_left_q - 18'(acc_bc);
        addr_after   = next_addr_q + 29'(acc_bc);
        burst_after  = (wl_after >= 18'(BL)) ? BL : wl_after[7:0];
        // Credit already charges a command accepted this cycle, allowing back-to-back issue
        credit_after = DEPTH - 16'(fill_q) - 16'(pending_q) - 16'(acc_bc);

        next_addr_d  = next_addr_q;
        words_left_d = words_left_q;
        if (frame_start) begin
            next_addr_d  = fb_base;
            words_left_d = FRAME;
        end else if ((state_q == S_REQ) && accept) begin
            next_addr_d  = addr_after;
            words_left_d = wl_after;
        end
        pending_d = pending_q + acc_bc - 8'(beat);

        read_d = read_q;
        addr_d = addr_q;
        bc_d   = bc_q;
        if (!read_q || accept) begin
            read_d = 1'b0;
            if (issue_ok && (wl_after != 18'd0) && (credit_after >= 16'(burst_after))) begin
                read_d = 1'b1;
                addr_d = addr_after;
                bc_d   = burst_after;
            end
        end

        rd_next  = rd_ptr_q + AW'(1);
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        fill_d   = fill_q + FW'(push) - FW'(pop);
        head_d   = head_q;
        if (push && ((fill_q == FW'(0)) || (pop && (fill_q == FW'(1))))) begin
            head_d = readdata;
        end else if (pop && (fill_q > FW'(1))) begin
            head_d = mem_q[rd_next];
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
            head_d   = '0;
        end

        uf_cond     = pix_ready && !pix_valid && busy;
        underflow_d = !frame_start && (underflow_q || uf_cond);
    end

    always_ff @(posedge systemClock) begin
        if (!reset_n) begin
            next_addr_q  <= '0;
            words_left_q <= '0;
            pending_q    <= '0;
            read_q       <= 1'b0;
            addr_q       <= '0;
            bc_q         <= '0;
            fill_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            head_q       <= '0;
            underflow_q  <= 1'b0;
        end else begin
            next_addr_q  <= next_addr_d;
            words_left_q <= words_left_d;
            pending_q    <= pending_d;
            read_q       <= read_d;
            addr_q       <= addr_d;
            bc_q         <= bc_d;
            fill_q       <= fill_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            head_q       <= head_d;
            underflow_q  <= underflow_d;
        end
    end

    always_ff @(posedge systemClock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= readdata;
        end
    end

`ifdef FB_SCANOUT_UNDERFLOW_CNT_EN
    logic [15:0] uf_cnt_q, uf_cnt_d;

    always_comb begin
        uf_cnt_d = uf_cnt_q;
        if (frame_start) begin
            uf_cnt_d = '0;
        end else if (uf_cond && (uf_cnt_q != 16'hFFFF)) begin
            uf_cnt_d = uf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge systemClock) begin
        if (!reset_n) begin
            uf_cnt_q <= '0;
        end else begin
            uf_cnt_q <= uf_cnt_d;
        end
    end

    assign underflow_count = uf_cnt_q;
`endif

    assign address    = addr_q;
    assign burstcount = bc_q;
    assign read       = read_q;
    assign byteenable = 8'hFF;
    assign pix_data   = head_q;
    assign pix_valid  = (fill_q != FW'(0));
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_fb_scanout_reader.sv
// Bench for fb_scanout_reader: Avalon slave model with command/data scoreboards.
`timescale 1ns/1ps
module tb_fb_scanout_reader;

    localparam int FW_N    = 20;
    localparam int BL_N    = 8;
    localparam int DEPTH_N = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [28:0] fb_base;
    logic        frame_start;
    logic [28:0] address;
    logic [7:0]  burstcount;
    logic        read;
    logic        waitrequest;
    logic [63:0] readdata;
    logic        readdatavalid;
    logic [7:0]  byteenable;
    logic [63:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        busy;
    logic        underflow;
`ifdef FB_SCANOUT_UNDERFLOW_CNT_EN
    logic [15:0] underflow_count;
`endif

    always #5 clk = ~clk;

    fb_scanout_reader #(
        .FRAME_WORDS (FW_N),
        .BURST_LEN   (BL_N),
        .FIFO_DEPTH  (DEPTH_N)
    ) dut (
        .systemClock   (clk),
        .reset_n       (reset_n),
        .fb_base       (fb_base),
        .frame_start   (frame_start),
        .address       (address),
        .burstcount    (burstcount),
        .read          (read),
        .waitrequest   (waitrequest),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .byteenable    (byteenable),
        .pix_data      (pix_data),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .busy          (busy),
        .underflow     (underflow)
`ifdef FB_SCANOUT_UNDERFLOW_CNT_EN
        ,
        .underflow_count (underflow_count)
`endif
    );

    typedef struct packed {
        logic [28:0] a;
        logic [7:0]  bc;
    } cmd_t;

    int          checks = 0;
    int          failures = 0;
    cmd_t        exp_cmd [$];
    logic [63:0] exp_data [$];
    logic [28:0] beat_q [$];
    int          stall_budget = 0;
    int          rdv_mode = 1;
    int          pr_mode = 0;
    int          beat_allow = 0;
    bit          stray_req = 1'b0;
    int          cmd_count = 0;
    int          inflight = 0;
    bit          prev_stall = 1'b0;
    logic [28:0] prev_addr = '0;
    logic [7:0]  prev_bc = '0;

    function automatic logic [63:0] word_of(input logic [28:0] a);
        return {a ^ 29'h0A5A_5A5A, 6'd0, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave model and monitors; inputs change here so they are stable at the next rising edge
    always @(negedge clk) begin
        cmd_t        c;
        logic [63:0] e;
        readdatavalid = 1'b0;
        readdata      = '0;
        if (stray_req && frame_start) begin
            readdatavalid = 1'b1;
            readdata      = 64'hDEAD_BEEF_DEAD_BEEF;
            stray_req     = 1'b0;
        end else if (beat_q.size() > 0 &&
                     (rdv_mode == 1 || (rdv_mode == 2 && $urandom_range(0, 2) != 0) || beat_allow > 0)) begin
            if (beat_allow > 0) beat_allow--;
            readdatavalid = 1'b1;
            readdata      = word_of(beat_q.pop_front());
        end
        waitrequest = (read === 1'b1) && (stall_budget > 0);
        if (waitrequest) stall_budget--;
        case (pr_mode)
            0:       pix_ready = 1'b0;
            1:       pix_ready = 1'b1;
            default: pix_ready = 1'($urandom_range(0, 1));
        endcase

        if (prev_stall) begin
            chk("hold_read", 64'(read), 64'(1));
            chk("hold_addr", 64'(address), 64'(prev_addr));
            chk("hold_bc", 64'(burstcount), 64'(prev_bc));
        end
        prev_stall = (read === 1'b1) && waitrequest;
        prev_addr  = address;
        prev_bc    = burstcount;

        if ((read === 1'b1) && !waitrequest) begin
            cmd_count++;
            if (exp_cmd.size() == 0) c = '0;
            else c = exp_cmd.pop_front();
            chk("cmd_addr", 64'(address), 64'(c.a));
            chk("cmd_bc", 64'(burstcount), 64'(c.bc));
            chk("credit", 64'(inflight + int'(burstcount) <= DEPTH_N), 64'(1));
            inflight += int'(burstcount);
            for (int i = 0; i < int'(burstcount); i++) beat_q.push_back(address + 29'(i));
        end

        if ((pix_valid === 1'b1) && pix_ready) begin
            if (exp_data.size() == 0) e = 64'hFFFF_FFFF_FFFF_FFFF;
            else e = exp_data.pop_front();
            chk("pix_data", pix_data, e);
            inflight--;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic start_frame(input logic [28:0] base);
        logic [28:0] a;
        int          rem;
        int          bc;
        a   = base;
        rem = FW_N;
        exp_cmd.delete();
        exp_data.delete();
        inflight = 0;
        while (rem > 0) begin
            bc = (rem > BL_N) ? BL_N : rem;
            exp_cmd.push_back({a, 8'(bc)});
            a   = a + 29'(bc);
            rem = rem - bc;
        end
        for (int i = 0; i < FW_N; i++) exp_data.push_back(word_of(base + 29'(i)));
        fb_base     = base;
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while ((busy || exp_data.size() != 0) && n < 2000) begin
            step(1);
            n++;
        end
        chk(tag, 64'(n < 2000), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int hi;
        reset_n     = 1'b0;
        fb_base     = '0;
        frame_start = 1'b0;
        step(3);
        chk("rst_read", 64'(read), 64'(0));
        chk("rst_address", 64'(address), 64'(0));
        chk("rst_burstcount", 64'(burstcount), 64'(0));
        chk("rst_pix_valid", 64'(pix_valid), 64'(0));
        chk("rst_pix_data", pix_data, 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_underflow", 64'(underflow), 64'(0));
        chk("byteenable", 64'(byteenable), 64'h0FF);
        reset_n = 1'b1;
        step(2);

        // Three bursts 8/8/4, first command stalled for five cycles
        pr_mode      = 1;
        rdv_mode     = 2;
        stall_budget = 5;
        cmd_count    = 0;
        start_frame(29'h0700_0000);
        wait_done("t1_done");
        chk("t1_cmd_count", 64'(cmd_count), 64'(3));
        chk("t1_cmd_left", 64'(exp_cmd.size()), 64'(0));
        chk("t1_stall_used", 64'(stall_budget), 64'(0));
        chk("t1_busy", 64'(busy), 64'(0));
        chk("t1_underflow_sticky", 64'(underflow), 64'(1));

        // Back-pressure: no data returned, consumer stalled
        pr_mode   = 0;
        rdv_mode  = 0;
        cmd_count = 0;
        start_frame(29'h0000_2000);
        chk("t2_uf_cleared", 64'(underflow), 64'(0));
        pr_mode = 1;
        step(3);
        pr_mode = 0;
        step(1);
        chk("t2_underflow", 64'(underflow), 64'(1));
`ifdef FB_SCANOUT_UNDERFLOW_CNT_EN
        chk("t2_underflow_count", 64'(underflow_count), 64'(3));
`endif
        n = 0;
        while (cmd_count < 2 && n < 100) begin
            step(1);
            n++;
        end
        chk("t2_two_bursts", 64'(cmd_count), 64'(2));
        step(2);
        hi = 0;
        beat_allow = 10;
        for (int i = 0; i < 20; i++) begin
            if (read) hi++;
            step(1);
        end
        chk("t2_no_credit_read", 64'(hi), 64'(0));
        chk("t2_cmd_count", 64'(cmd_count), 64'(2));
        chk("t2_pix_valid", 64'(pix_valid), 64'(1));

        // Restart with 6 beats still pending
        cmd_count = 0;
        start_frame(29'h0000_0100);
        chk("t3_uf_cleared", 64'(underflow), 64'(0));
        chk("t3_flushed", 64'(pix_valid), 64'(0));
        chk("t3_busy", 64'(busy), 64'(1));
        rdv_mode = 1;
        pr_mode  = 2;
        wait_done("t3_done");
        chk("t3_cmd_count", 64'(cmd_count), 64'(3));
        chk("t3_cmd_left", 64'(exp_cmd.size()), 64'(0));

        // Stray beat on the start cycle, then address wrap
        rdv_mode  = 2;
        cmd_count = 0;
        stray_req = 1'b1;
        start_frame(29'h1FFF_FFFC);
        wait_done("t4_done");
        chk("t4_cmd_count", 64'(cmd_count), 64'(3));
        chk("t4_cmd_left", 64'(exp_cmd.size()), 64'(0));
        chk("t4_busy", 64'(busy), 64'(0));
        step(5);
        chk("t4_idle_valid", 64'(pix_valid), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
